validador_pecas: RTL
====================

# validador_pecas

Validation and storage stage downstream of the piece-placement FSM. On each rising edge of `valida` it takes one ship (type, anchor X/Y, direction, player), walks its cells one per clock against that player's occupancy board, flags a conflict on any out-of-bounds or occupied cell, and otherwise commits the ship's cells to the board. It owns both players' boards and exposes a read port for the game-execution stage.

## Interface
Parameters:
- `N`, 10: board side; valid coordinates are 0..N-1.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `valida` in 1: validation request; rising edge starts a check.
- `tipo` in 3: ship type. 0 submarino (len 1), 1 cruzador (len 2), 2 hidroavião (3 cells, shaped), 3 encouraçado (len 4), 4 porta-aviões (len 5). Codes 5..7 are invalid.
- `jogador` in 1: selects board 0 or 1.
- `X1`, `Y1` in 4: anchor cell.
- `direcao` in 1: 0 = horizontal (+X), 1 = vertical (+Y).
- `limpa` in 1: synchronous clear of both boards; honoured only in IDLE.
- `conflito` out 1: result of the last check; held until the next accepted start.
- `done` out 1: one-cycle pulse when a check completes, whether stored or rejected.
- `busy` out 1: high in any state except IDLE.
- `rd_jogador` in 1, `rd_x` in 4, `rd_y` in 4: read address.
- `rd_ocupado` out 1: combinational occupancy of the addressed cell; 0 if the address is out of range.

## Operation
- Start condition: `valida & ~valida_q` while in IDLE. `valida_q` is a registered copy of `valida`.
  - A rising edge while busy is ignored.
  - A level held high does not retrigger.
- Inputs are latched at start; later changes to them have no effect.
- Cell i (0-based) of the ship is (X1+dx, Y1+dy), computed in 5 bits so overflow is visible. Offsets:
  - Straight ships, horizontal: (i,0). Vertical: (0,i).
  - Hidroavião, horizontal: (0,0), (1,1), (2,0).
  - Hidroavião, vertical: (0,0), (1,1), (0,2).
- A cell conflicts if its x ≥ N, its y ≥ N, or it is already set on the selected board.
- FSM:
  - IDLE: on start, latch inputs, set i=0, clear `conflito`. If `tipo` > 4, go to DONE with `conflito`=1. Otherwise go to CHECK.
  - CHECK: test cell i. On conflict, set `conflito`=1 and go to DONE (early exit). Else if i = len-1, set i=0 and go to WRITE. Else i++.
  - WRITE: set cell i on the board. If i = len-1, go to DONE. Else i++.
  - DONE: pulse `done` for one cycle, then go to IDLE.
- The board is never partially written: writes happen only after every cell has passed.
- `limpa` outside IDLE is ignored.
- Board writes and `limpa` never coincide, because `limpa` acts only in IDLE.
- The read port reflects a write starting the cycle after the write clock edge.

## Timing
- Reset values:
  - `conflito`=0, `done`=0, `busy`=0.
  - Both boards all zero.
  - FSM in IDLE, i=0, `valida_q`=0.
- Latency, start edge to `done` high:
  - Accepted ship: 1 + 2·len cycles (IDLE→CHECK×len→WRITE×len→DONE).
  - Rejection at cell k: 1 + (k+1) cycles.
  - Invalid `tipo`: 1 cycle.
- `conflito` is valid from the cycle `done` is high and stays stable until the next accepted start.
- Back-to-back starts: earliest next accepted start is the cycle after DONE, which requires `valida` to drop and rise again.
- Reset asserted mid-operation: immediate return to IDLE, boards cleared, all outputs 0. No partial ship survives.

## Structure
- Shared package `batalha_pkg` holds:
  - `N`.
  - Ship type codes (SUBMARINO=0 … PORTA_AVIOES=4).
  - Ship length function.
  - FSM state enum.
  - Player index type.
- Sub-module `celula_peca`: combinational (`tipo`, `direcao`, i) → (dx, dy, last). It isolates the shape table so later shapes can be added there.
- Boards are two N·N flop vectors, indexed as y·N+x.

## Test plan
- Place porta-aviões on board 0 (reset, `tipo`=4, X=2, Y=3, `direcao`=0, `jogador`=0, rise `valida`):
  - `done` 11 cycles after the edge, `conflito`=0.
  - `rd_ocupado`=1 at (2..6,3); 0 at (7,3) and at (2,4).
- Overlap: repeat the same request:
  - `done` 2 cycles after the edge, `conflito`=1.
  - Board unchanged.
- Out of bounds: encouraçado at X=7, Y=0, `direcao`=0:
  - Fails at cell 3 (x=10), `done` at cycle 5, `conflito`=1.
  - (7,0), (8,0), (9,0) remain 0.
- Player isolation: test 1's placement with `jogador`=1 after test 1 → `conflito`=0, both boards set.
- Hidroavião shape:
  - Vertical at (9,0) → `conflito`=1 (second cell at x=10).
  - Horizontal at (0,0) → `conflito`=0; cells (0,0), (1,1), (2,0) set and (1,0) clear.
- Control corner cases:
  - Hold `valida` high for 20 cycles → exactly one `done`.
  - Raise `valida` again while busy → ignored.
  - Assert `reset` during WRITE of a porta-aviões → all cells 0 and `busy`=0 immediately.
  - `tipo`=6 → `done` after 1 cycle, `conflito`=1.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared definitions for the battleship piece stages.
// Holds the board size, ship type codes, the ship length table, the validator
// FSM states, the player index type and the latched ship request payload.
package batalha_pkg;

    localparam int unsigned N          = 10;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned CELL_W     = 5;
    localparam int unsigned TIPO_W     = 3;
    localparam int unsigned PECA_IDX_W = 3;

    localparam logic [TIPO_W-1:0] SUBMARINO    = 3'd0;
    localparam logic [TIPO_W-1:0] CRUZADOR     = 3'd1;
    localparam logic [TIPO_W-1:0] HIDROAVIAO   = 3'd2;
    localparam logic [TIPO_W-1:0] ENCOURACADO  = 3'd3;
    localparam logic [TIPO_W-1:0] PORTA_AVIOES = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_DONE
    } estado_t;

    typedef logic jogador_t;

    typedef struct packed {
        logic [TIPO_W-1:0]  tipo;
        jogador_t           jogador;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               direcao;
    } peca_t;

    // Number of cells of a ship; 0 for the unused codes.
    function automatic logic [PECA_IDX_W-1:0] comprimento(input logic [TIPO_W-1:0] tipo);
        case (tipo)
            SUBMARINO:    comprimento = 3'd1;
            CRUZADOR:     comprimento = 3'd2;
            HIDROAVIAO:   comprimento = 3'd3;
            ENCOURACADO:  comprimento = 3'd4;
            PORTA_AVIOES: comprimento = 3'd5;
            default:      comprimento = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/validador_pecas_if.sv
// Request / result / read-port bundle of the piece validator.
// master: placement FSM and game stage side (drives request and read address).
// slave : validador_pecas (returns conflito, done, busy, rd_ocupado).
interface validador_pecas_if;
    import batalha_pkg::*;

    logic                valida;
    logic [TIPO_W-1:0]   tipo;
    logic                jogador;
    logic [COORD_W-1:0]  X1;
    logic [COORD_W-1:0]  Y1;
    logic                direcao;
    logic                limpa;
    logic                conflito;
    logic                done;
    logic                busy;
    logic                rd_jogador;
    logic [COORD_W-1:0]  rd_x;
    logic [COORD_W-1:0]  rd_y;
    logic                rd_ocupado;

    modport master (
        output valida, tipo, jogador, X1, Y1, direcao, limpa,
        output rd_jogador, rd_x, rd_y,
        input  conflito, done, busy, rd_ocupado
    );

    modport slave (
        input  valida, tipo, jogador, X1, Y1, direcao, limpa,
        input  rd_jogador, rd_x, rd_y,
        output conflito, done, busy, rd_ocupado
    );

endinterface

// File: rtl/celula_peca.sv
// Shape table: offset of cell i of a ship relative to its anchor.
// Ports: tipo, direcao, i in; dx_c, dy_c (offsets), last_c (i is the final cell) out.
module celula_peca
    import batalha_pkg::*;
(
    input  logic [TIPO_W-1:0]     tipo,
    input  logic                  direcao,
    input  logic [PECA_IDX_W-1:0] i,
    output logic [PECA_IDX_W-1:0] dx_c,
    output logic [PECA_IDX_W-1:0] dy_c,
    output logic                  last_c
);

    // Straight ships run along the direction; the seaplane is a fixed three-cell V.
    always_comb begin
        dx_c   = '0;
        dy_c   = '0;
        last_c = (i == comprimento(tipo) - 3'd1);
        if (tipo == HIDROAVIAO) begin
            case (i)
                3'd1: begin
                    dx_c = 3'd1;
                    dy_c = 3'd1;
                end
                3'd2: begin
                    if (direcao) dy_c = 3'd2;
                    else         dx_c = 3'd2;
                end
                default: ;
            endcase
        end else if (direcao) begin
            dy_c = i;
        end else begin
            dx_c = i;
        end
    end

endmodule

// File: rtl/validador_pecas.sv
// Validates one ship per valida rising edge against the selected player's board
// and, if every cell is free and in range, commits it. Owns both boards.
// Ports: clk, reset (async, active low), bus (validador_pecas_if.slave):
//   request valida/tipo/jogador/X1/Y1/direcao, limpa (clear, idle only),
//   result conflito/done/busy, read port rd_jogador/rd_x/rd_y -> rd_ocupado.
module validador_pecas
    import batalha_pkg::*;
#(
    parameter int unsigned N = batalha_pkg::N
) (
    input  logic             clk,
    input  logic             reset,
    validador_pecas_if.slave bus
);

    localparam int unsigned BOARD_W = N * N;
    localparam int unsigned ADDR_W  = $clog2(BOARD_W);

    estado_t                 state_q, state_d;
    peca_t                   peca_q;
    logic [PECA_IDX_W-1:0]   i_q, i_d;
    logic                    valida_q;
    logic                    conflito_q, conflito_d;
    logic                    done_q, busy_q;
    logic [1:0][BOARD_W-1:0] board_q;

    logic                    start_c, lat_en_c, wr_en_c, clr_c;
    logic [PECA_IDX_W-1:0]   dx_c, dy_c;
    logic                    last_c;
    logic [CELL_W-1:0]       x_c, y_c;
    logic [ADDR_W-1:0]       idx_c, rd_idx_c;
    logic                    fora_c, conflito_cel_c, rd_fora_c;

    celula_peca u_celula (
        .tipo    (peca_q.tipo),
        .direcao (peca_q.direcao),
        .i       (i_q),
        .dx_c    (dx_c),
        .dy_c    (dy_c),
        .last_c  (last_c)
    );

    // Cell coordinates one bit wider than the anchor so overflow past N is visible.
    assign x_c            = CELL_W'(peca_q.x) + CELL_W'(dx_c);
    assign y_c            = CELL_W'(peca_q.y) + CELL_W'(dy_c);
    assign fora_c         = (x_c >= CELL_W'(N)) || (y_c >= CELL_W'(N));
    assign idx_c          = ADDR_W'(y_c) * ADDR_W'(N) + ADDR_W'(x_c);
    assign conflito_cel_c = fora_c || board_q[peca_q.jogador][idx_c];

    assign start_c = bus.valida & ~valida_q;

    // Read port for the game stage; out-of-range addresses read as empty.
    assign rd_fora_c      = (bus.rd_x >= COORD_W'(N)) || (bus.rd_y >= COORD_W'(N));
    assign rd_idx_c       = ADDR_W'(bus.rd_y) * ADDR_W'(N) + ADDR_W'(bus.rd_x);
    assign bus.rd_ocupado = !rd_fora_c && board_q[bus.rd_jogador][rd_idx_c];

    assign bus.conflito = conflito_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

    // Next state: check every cell first, write only after all passed.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        conflito_d = conflito_q;
        lat_en_c   = 1'b0;
        wr_en_c    = 1'b0;
        clr_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                clr_c = bus.limpa;
                if (start_c) begin
                    lat_en_c   = 1'b1;
                    i_d        = '0;
                    conflito_d = 1'b0;
                    if (bus.tipo > PORTA_AVIOES) begin
                        conflito_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (conflito_cel_c) begin
                    conflito_d = 1'b1;
                    state_d    = S_DONE;
                end else if (last_c) begin
                    i_d     = '0;
                    state_d = S_WRITE;
                end else begin
                    i_d = i_q + PECA_IDX_W'(1);
                end
            end
            S_WRITE: begin
                wr_en_c = 1'b1;
                if (last_c) state_d = S_DONE;
                else        i_d     = i_q + PECA_IDX_W'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, latched request, registered outputs and both boards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            valida_q   <= 1'b0;
            conflito_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            peca_q     <= '0;
            board_q    <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            valida_q   <= bus.valida;
            conflito_q <= conflito_d;
            done_q     <= (state_d == S_DONE);
            busy_q     <= (state_d != S_IDLE);
            if (lat_en_c) begin
                peca_q <= '{tipo: bus.tipo, jogador: bus.jogador, x: bus.X1,
                            y: bus.Y1, direcao: bus.direcao};
            end
            if (wr_en_c) begin
                board_q[peca_q.jogador][idx_c] <= 1'b1;
            end else if (clr_c) begin
                board_q <= '0;
            end
        end
    end

endmodule
